// File: rtl/line_position_decoder.sv
// rtl/line_position_decoder.sv - reflectance array debounce, line classification and steering command
// Heading is held through short dropouts; stop is forced after LOST_TIMEOUT line-less ticks.
module line_position_decoder #(
  parameter int SAMPLE_DIV   = 500,
  parameter int STABLE_COUNT = 4,
  parameter int LOST_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] sensor_in,
  output logic [1:0] direction_command,
  output logic       cmd_valid,
  output logic       line_lost
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam int LW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_COUNT);
  localparam logic [LW-1:0] LOST_MAX = LW'(LOST_TIMEOUT);

  typedef enum logic [1:0] {IDLE, TRACK, SEARCH, LOST} state_t;

  logic [7:0]    sync_meta_q, s_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    acc_q, acc_d;
  logic [LW-1:0] lost_cnt_q, lost_cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          tick;
  logic          accept;

  function automatic logic [1:0] classify(input logic [7:0] p);
    logic [3:0]        n;
    logic signed [5:0] sum;
    n   = '0;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        n   = n + 1'b1;
        sum = sum + 6'(2 * i - 7);
      end
    end
    if (n >= 4'd6)                          classify = 2'd3;
    else if (sum > $signed({2'b00, n}))     classify = 2'd2;
    else if (sum < -$signed({2'b00, n}))    classify = 2'd1;
    else                                    classify = 2'd0;
  endfunction

  assign tick = enable && (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= '0;
      s_q         <= '0;
      div_cnt_q   <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      acc_q       <= '0;
      lost_cnt_q  <= '0;
      state_q     <= IDLE;
      cmd_q       <= 2'd3;
      cmd_valid_q <= 1'b0;
    end else begin
      sync_meta_q <= sensor_in;
      s_q         <= sync_meta_q;
      div_cnt_q   <= div_cnt_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      acc_q       <= acc_d;
      lost_cnt_q  <= lost_cnt_d;
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Prescaler and debounce; accept fires only on the tick where stab first reaches its ceiling.
  always_comb begin
    div_cnt_d = div_cnt_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    acc_d     = acc_q;
    accept    = 1'b0;
    if (!enable) begin
      div_cnt_d = '0;
      cand_d    = '0;
      stab_d    = '0;
      acc_d     = '0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        if (s_q == cand_q) begin
          if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
        end else begin
          cand_d = s_q;
          stab_d = SW'(1);
        end
        accept = ((stab_d == STAB_MAX) && (stab_q != STAB_MAX)) ||
                 ((STABLE_COUNT == 1) && (s_q != cand_q));
        if (accept) acc_d = cand_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    lost_cnt_d = lost_cnt_q;
    if (!enable) begin
      state_d    = IDLE;
      cmd_d      = 2'd3;
      lost_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRACK;
          cmd_d   = 2'd3;
        end
        TRACK: begin
          if (accept) begin
            if (acc_d != 8'd0) begin
              cmd_d = classify(acc_d);
            end else begin
              state_d    = SEARCH;
              lost_cnt_d = '0;
            end
          end
        end
        SEARCH: begin
          // A reacquired line wins over a timeout landing on the same tick.
          if (accept && (acc_d != 8'd0)) begin
            state_d = TRACK;
            cmd_d   = classify(acc_d);
          end else if (tick) begin
            lost_cnt_d = lost_cnt_q + 1'b1;
            if (lost_cnt_d == LOST_MAX) begin
              state_d = LOST;
              cmd_d   = 2'd3;
            end
          end
        end
        default: begin
          cmd_d = 2'd3;
          if (accept && (acc_d != 8'd0)) begin
            state_d = TRACK;
            cmd_d   = classify(acc_d);
          end
        end
      endcase
    end
    cmd_valid_d = enable && (cmd_d != cmd_q);
  end

  always_comb begin
    direction_command = cmd_q;
    cmd_valid         = cmd_valid_q;
    line_lost         = (state_q == LOST);
  end

endmodule

// File: doc/line_position_decoder.md
# line_position_decoder

Upstream stage of the balance car's steering path. Samples the 8-bit reflectance sensor array, debounces it, classifies line position, and drives the 2-bit `direction_command` consumed by the motor direction stage: 0 straight, 1 turn right, 2 turn left, 3 stop. Also holds the last heading briefly through line dropouts and declares line loss after a timeout.

## Interface
- `SAMPLE_DIV`, 500: clock cycles per sensor sample tick (≥2)
- `STABLE_COUNT`, 4: consecutive identical samples needed to accept a pattern (≥1)
- `LOST_TIMEOUT`, 64: sample ticks with no line before stop is forced (≥1)

- `clk`  in  1  system clock; sole clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  1 = run; 0 = idle, command stop
- `sensor_in`  in  8  reflectance bits, 1 = line seen; bit 7 leftmost, bit 0 rightmost; asynchronous
- `direction_command`  out  2  registered command (0 straight, 1 right, 2 left, 3 stop)
- `cmd_valid`  out  1  one-cycle pulse when `direction_command` changes value
- `line_lost`  out  1  1 while in LOST

## Operation
- Input: 2-flop synchronizer on `sensor_in`; all logic uses synced value `s`.
- Prescaler `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. `tick` = 1 when `div_cnt`==SAMPLE_DIV-1 and `enable`=1. With `enable`=0, `div_cnt` is held at 0.
- Debounce on `tick`:
  - If `s`==`cand`, `stab` increments, saturating at STABLE_COUNT.
  - Else `cand`<=`s` and `stab`<=1.
  - Accept event when the new `stab` value equals STABLE_COUNT and the previous value did not (or STABLE_COUNT=1 and `cand` changes). This sets `acc`<=`cand`.
- Classification of `acc`:
  - `N` = popcount (4 bits).
  - `S` = Σ over set bits i of (2i−7), 6-bit signed, range −16..+16.
  - `acc`==0 → no line.
  - N≥6 → stop (3; stop bar).
  - else S>N → left (2); S<−N → right (1); otherwise straight (0).
- States:
  - IDLE: command 3, line_lost 0. Leave to TRACK when `enable`=1.
  - TRACK: on accept with `acc`≠0, command<=class(`acc`). On accept with `acc`==0, go to SEARCH, `lost_cnt`<=0, command held.
  - SEARCH: command held. Each tick increments `lost_cnt`. When `lost_cnt` reaches LOST_TIMEOUT, go to LOST and set command<=3. On accept with `acc`≠0, go to TRACK and command<=class(`acc`); this takes priority over timeout on the same tick.
  - LOST: command 3, line_lost 1. On accept with `acc`≠0, go to TRACK and command<=class(`acc`).
  - Any state with `enable`=0 → IDLE next cycle. `cand`, `stab`, `acc`, `lost_cnt` and `div_cnt` are all cleared.
- `cmd_valid` = registered (next_cmd ≠ cmd). It pulses the same cycle the new command appears.

## Timing
- Reset values: `direction_command`=3, `cmd_valid`=0, `line_lost`=0, state IDLE, all counters 0, `cand`=`acc`=0.
- Reset or `enable` drop mid-operation: outputs return to reset values the next cycle. No partial debounce state survives.
- Latency: sensor change → 2 sync cycles, then the STABLE_COUNT-th following tick. Command is updated 1 cycle after that accepting tick. Worst case 2+STABLE_COUNT·SAMPLE_DIV+1 cycles.
- Line-loss stop: command goes to 3 one cycle after the LOST_TIMEOUT-th tick following the zero-pattern accept.
- A pattern change held for fewer than STABLE_COUNT ticks never alters outputs.
- `cmd_valid` never asserts on consecutive cycles unless the command changes on both.

## Test plan
Parameters: SAMPLE_DIV=4, STABLE_COUNT=3, LOST_TIMEOUT=5.
- **Reset/acquire:** assert `reset` → outputs 3/0/0. Release, `enable`=1, `sensor_in`=00011000 → command 0 one cycle after the 3rd tick, with a single `cmd_valid` pulse.
- **Classification sweep:** hold each pattern ≥4 ticks. 00001100→1, 00110000→2, 00001110→1, 11100000→2, 00011100→0, 00010000→0, 11111100→3 with `line_lost`=0.
- **Glitch rejection:** tracking 0, apply 00000011 for exactly 2 ticks then restore 00011000 → command stays 0, no `cmd_valid`.
- **Dropout:** tracking 1, `sensor_in`=0 → command stays 1 for 4 more ticks after accept, then goes to 3 with `line_lost`=1 on the 5th. Apply 00011000 → after 3 ticks command 0, `line_lost`=0.
- **Short dropout:** zero accepted, line returns so that the accept lands on the 5th SEARCH tick → command follows class, never 3.
- **Enable/reset mid-run:** drop `enable` in SEARCH → next cycle command 3, `line_lost` 0, `div_cnt` 0. Re-enable → needs 3 fresh ticks. Repeat with `reset` during TRACK → identical outcome.
